// File: rtl/calc_host_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : calc_host_mailbox
// Purpose  : Loads calculator operands into dmem while the CPU is held in reset.
//            It then releases the CPU, snoops the result store, and returns the
//            stored value on a valid/ready response channel.
// Options  : CALC_MBOX_CYCLE_COUNT_EN adds the rsp_cycles output.
// Revision : 1.0  initial release
// ============================================================================
module calc_host_mailbox #(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_op_a,
  input  logic [31:0] req_op_b,
  input  logic [3:0]  req_opcode,
  output logic        cpu_reset,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout
`ifdef CALC_MBOX_CYCLE_COUNT_EN
  ,
  output logic [15:0] rsp_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_A   = 3'd1,
    S_WR_B   = 3'd2,
    S_WR_OP  = 3'd3,
    S_WR_CLR = 3'd4,
    S_HOLD   = 3'd5,
    S_RUN    = 3'd6,
    S_RESP   = 3'd7
  } state_t;

  localparam logic [31:0] C_ADDR_B      = BASE_ADDR + 32'h4;
  localparam logic [31:0] C_ADDR_OP     = BASE_ADDR + 32'h8;
  localparam logic [31:0] C_ADDR_RESULT = BASE_ADDR + 32'hC;
  localparam logic [31:0] C_HOLD_LAST   = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] C_RUN_LAST    = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_op_b;
  logic [3:0]  r_opcode;
  logic        w_capture;

  assign req_ready = (r_state == S_IDLE);
  assign w_capture = cpu_memwrite && (cpu_addr == C_ADDR_RESULT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 32'd0;
      r_op_b      <= 32'd0;
      r_opcode    <= 4'd0;
      cpu_reset   <= 1'b1;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_result  <= 32'd0;
      rsp_timeout <= 1'b0;
`ifdef CALC_MBOX_CYCLE_COUNT_EN
      rsp_cycles  <= 16'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // Write outputs are registered, so the first dmem write is set up on the accept edge.
          if (req_valid && req_ready) begin
            r_op_b    <= req_op_b;
            r_opcode  <= req_opcode;
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= req_op_a;
            r_state   <= S_WR_A;
          end
        end
        S_WR_A: begin
          mem_addr  <= C_ADDR_B;
          mem_wdata <= r_op_b;
          r_state   <= S_WR_B;
        end
        S_WR_B: begin
          mem_addr  <= C_ADDR_OP;
          mem_wdata <= {28'd0, r_opcode};
          r_state   <= S_WR_OP;
        end
        S_WR_OP: begin
          mem_addr  <= C_ADDR_RESULT;
          mem_wdata <= 32'd0;
          r_state   <= S_WR_CLR;
        end
        S_WR_CLR: begin
          mem_we    <= 1'b0;
          mem_addr  <= 32'd0;
          mem_wdata <= 32'd0;
          r_cnt     <= 32'd0;
          r_state   <= S_HOLD;
        end
        S_HOLD: begin
          if (r_cnt == C_HOLD_LAST) begin
            cpu_reset <= 1'b0;
            r_cnt     <= 32'd0;
            r_state   <= S_RUN;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RUN: begin
          // A result store in the final run cycle still counts as a capture.
          if (w_capture || (r_cnt == C_RUN_LAST)) begin
            rsp_result  <= w_capture ? cpu_wdata : 32'd0;
            rsp_timeout <= !w_capture;
            rsp_valid   <= 1'b1;
            cpu_reset   <= 1'b1;
`ifdef CALC_MBOX_CYCLE_COUNT_EN
            rsp_cycles  <= (r_cnt > 32'h0000_FFFF) ? 16'hFFFF : r_cnt[15:0];
`endif
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
